// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port word memory; one transaction in flight.
// Optional WAIT-state timeout response is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_store,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    input  logic              req1_valid,
    input  logic              req1_store,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic              l1_mem_valid,
    output logic              l1_mem_store,
    output logic [ADDR_W-1:0] l1_mem_addr,
    output logic [DATA_W-1:0] l1_mem_wdata,
    input  logic              mem_l1_valid,
    input  logic [DATA_W-1:0] mem_l1_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [31:0] TIMEOUT_PATTERN = 32'hDEAD_BEEF;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    state_t            state_q, state_d;
    logic              last_grant_q, gnt_q;
    logic              win, accept, timeout;
    logic              mem_store_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q, rdata_d;
    logic              mem_done;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    // Memory pulse takes priority over a timeout landing in the same cycle.
    assign timeout = (state_q == WAIT) && !mem_l1_valid &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // On a tie the port not granted most recently wins.
    always_comb begin
        if (req0_valid && req1_valid) win = ~last_grant_q;
        else                          win = req1_valid;
    end

    assign accept   = (state_q == IDLE) && (req0_valid || req1_valid) && !rst;
    assign mem_done = (state_q == WAIT) && mem_l1_valid;

    always_comb begin
        if (timeout)          rdata_d = DATA_W'(TIMEOUT_PATTERN);
        else if (mem_store_q) rdata_d = '0;
        else                  rdata_d = mem_l1_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req0_valid || req1_valid) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (mem_l1_valid || timeout) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            mem_store_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            if (accept) begin
                gnt_q        <= win;
                last_grant_q <= win;
                mem_store_q  <= win ? req1_store : req0_store;
                mem_addr_q   <= win ? req1_addr  : req0_addr;
                mem_wdata_q  <= win ? req1_wdata : req0_wdata;
            end
            if (mem_done || timeout) begin
                if (gnt_q) rdata1_q <= rdata_d;
                else       rdata0_q <= rdata_d;
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == ISSUE)     cnt_q <= '0;
            else if (state_q == WAIT) cnt_q <= cnt_q + CNT_W'(1);
            if (mem_done)     err_q <= 1'b0;
            else if (timeout) err_q <= 1'b1;
        end
    end
`endif

    always_comb begin
        req0_ready   = accept && !win;
        req1_ready   = accept && win;
        l1_mem_valid = (state_q == ISSUE);
        rsp0_valid   = (state_q == RESP) && !gnt_q;
        rsp1_valid   = (state_q == RESP) && gnt_q;
`ifdef MEM_ARB_TIMEOUT_EN
        rsp0_err     = rsp0_valid && err_q;
        rsp1_err     = rsp1_valid && err_q;
`else
        rsp0_err     = 1'b0;
        rsp1_err     = 1'b0;
`endif
    end

    assign l1_mem_store = mem_store_q;
    assign l1_mem_addr  = mem_addr_q;
    assign l1_mem_wdata = mem_wdata_q;
    assign rsp0_rdata   = rdata0_q;
    assign rsp1_rdata   = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: word memory model, per-port response scoreboard, vector table and corner sequences.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req0_store = 1'b0, req1_valid = 1'b0, req1_store = 1'b0;
    logic [31:0] req0_addr = '0, req0_wdata = '0, req1_addr = '0, req1_wdata = '0;
    logic        req0_ready, rsp0_valid, rsp0_err, req1_ready, rsp1_valid, rsp1_err;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        l1_mem_valid, l1_mem_store;
    logic [31:0] l1_mem_addr, l1_mem_wdata;
    logic        mem_l1_valid;
    logic [31:0] mem_l1_rdata;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_store(req0_store), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
        .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_store(req1_store), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
        .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .l1_mem_valid(l1_mem_valid), .l1_mem_store(l1_mem_store), .l1_mem_addr(l1_mem_addr),
        .l1_mem_wdata(l1_mem_wdata), .mem_l1_valid(mem_l1_valid), .mem_l1_rdata(mem_l1_rdata)
    );

    // Memory model: word-indexed, response pulse mem_lat cycles after the issue cycle.
    logic [31:0] mem [0:255];
    logic        model_vld = 1'b0, inj_vld = 1'b0;
    logic [31:0] model_rdata = '0, inj_data = '0;
    int          mem_lat = 1;
    bit          mem_silent = 1'b0;
    bit          pend = 1'b0;
    int          mcnt = 0;
    logic        p_store;
    logic [7:0]  p_idx;
    logic [31:0] p_wd;

    assign mem_l1_valid = model_vld | inj_vld;
    assign mem_l1_rdata = inj_vld ? inj_data : model_rdata;

    always @(posedge clk) begin
        model_vld <= 1'b0;
        if (l1_mem_valid && !mem_silent) begin
            pend = 1'b1; mcnt = mem_lat;
            p_store = l1_mem_store; p_idx = l1_mem_addr[9:2]; p_wd = l1_mem_wdata;
        end
        if (pend) begin
            if (mcnt <= 1) begin
                model_vld   <= 1'b1;
                model_rdata <= p_store ? 32'h5A5A_5A5A : mem[p_idx];
                if (p_store) mem[p_idx] = p_wd;
                pend = 1'b0;
            end else begin
                mcnt--;
            end
        end
    end

    int tests = 0, fails = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] rdata; logic err; } exp_t;
    typedef struct { int port; logic st; logic [31:0] addr; logic [31:0] wdata; logic [31:0] exp; } vec_t;
    exp_t q0[$], q1[$];
    exp_t e0, e1;
    int   rcnt0 = 0, rcnt1 = 0, rsp_cyc0 = 0, rsp_cyc1 = 0;
    int   gport[$], gcyc[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // Scoreboard and grant monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (req0_ready || req1_ready) begin
                check("one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
                gport.push_back(req1_ready ? 1 : 0);
                gcyc.push_back(cyc);
            end
            if (rsp0_valid || rsp1_valid)
                check("one_rsp", {31'd0, rsp0_valid & rsp1_valid}, 32'd0);
            if (rsp0_valid) begin
                rcnt0++; rsp_cyc0 = cyc;
                if (q0.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rsp0_unexpected: got rsp0_valid with rdata %h, required no response", rsp0_rdata);
                end else begin
                    e0 = q0.pop_front();
                    check("rsp0_rdata", rsp0_rdata, e0.rdata);
                    check("rsp0_err", {31'd0, rsp0_err}, {31'd0, e0.err});
                end
            end
            if (rsp1_valid) begin
                rcnt1++; rsp_cyc1 = cyc;
                if (q1.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rsp1_unexpected: got rsp1_valid with rdata %h, required no response", rsp1_rdata);
                end else begin
                    e1 = q1.pop_front();
                    check("rsp1_rdata", rsp1_rdata, e1.rdata);
                    check("rsp1_err", {31'd0, rsp1_err}, {31'd0, e1.err});
                end
            end
        end
    end

    task automatic issue(input int port, input logic st, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee, input bit push, output int acc);
        bit   got = 1'b0;
        exp_t e;
        e.rdata = er; e.err = ee;
        if (port == 0) begin req0_valid = 1'b1; req0_store = st; req0_addr = a; req0_wdata = wd; end
        else           begin req1_valid = 1'b1; req1_store = st; req1_addr = a; req1_wdata = wd; end
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            got = (port == 0) ? req0_ready : req1_ready;
        end
        acc = cyc;
        if (!got) begin
            tests++; fails++;
            $display("FAIL accept_port%0d: ready stayed 0, required 1", port);
        end else if (push) begin
            if (port == 0) q0.push_back(e); else q1.push_back(e);
        end
        @(posedge clk); #1;
        if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain: %0d responses still pending, required 0", q0.size() + q1.size());
            q0.delete(); q1.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    vec_t vecs[8];
    int   acc, t0, r0, r1;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = i;
        vecs[0] = '{0, 1'b0, 32'h40,  32'h0,         32'h10};
        vecs[1] = '{1, 1'b1, 32'h80,  32'hCAFE_F00D, 32'h0};
        vecs[2] = '{1, 1'b0, 32'h80,  32'h0,         32'hCAFE_F00D};
        vecs[3] = '{0, 1'b0, 32'h0,   32'h0,         32'h0};
        vecs[4] = '{1, 1'b0, 32'hC,   32'h0,         32'h3};
        vecs[5] = '{0, 1'b1, 32'h10,  32'h1234_5678, 32'h0};
        vecs[6] = '{0, 1'b0, 32'h10,  32'h0,         32'h1234_5678};
        vecs[7] = '{1, 1'b0, 32'h3FC, 32'h0,         32'hFF};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_ctl", {30'd0, l1_mem_valid, l1_mem_store}, 32'd0);
        check("rst_mem_addr", l1_mem_addr, 32'd0);
        check("rst_mem_wdata", l1_mem_wdata, 32'd0);
        check("rst_rsp_flags", {26'd0, rsp0_valid, rsp0_err, rsp1_valid, rsp1_err, req0_ready, req1_ready}, 32'd0);
        check("rst_rdata0", rsp0_rdata, 32'd0);
        check("rst_rdata1", rsp1_rdata, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // First load on port 0: cycle-by-cycle timing.
        req0_valid = 1'b1; req0_store = 1'b0; req0_addr = 32'h40;
        @(negedge clk);
        check("t_ready", {30'd0, req0_ready, req1_ready}, 32'd2);
        e0.rdata = 32'h10; e0.err = 1'b0; q0.push_back(e0);
        t0 = cyc;
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk);
        check("t1_mem_valid", {30'd0, l1_mem_valid, l1_mem_store}, 32'd2);
        check("t1_mem_addr", l1_mem_addr, 32'h40);
        @(negedge clk);
        check("t2_mem_valid", {31'd0, l1_mem_valid}, 32'd0);
        check("t2_addr_hold", l1_mem_addr, 32'h40);
        @(negedge clk);
        check("t3_rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'd2);
        drain();
        check("t3_latency", rsp_cyc0 - t0, 32'd3);

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].port, vecs[i].st, vecs[i].addr, vecs[i].wdata, vecs[i].exp, 1'b0, 1'b1, acc);
            drain();
        end

        // Memory pulse while idle must be ignored.
        r0 = rcnt0; r1 = rcnt1;
        inj_vld = 1'b1; inj_data = 32'h0BAD_0BAD;
        @(posedge clk); #1 inj_vld = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_inj_rsp", rcnt0 + rcnt1, r0 + r1);
        check("idle_inj_mem", {31'd0, l1_mem_valid}, 32'd0);
        check("idle_inj_rdata0", rsp0_rdata, 32'h1234_5678);
        @(posedge clk); #1;
        issue(1, 1'b0, 32'h14, 32'h0, 32'h5, 1'b0, 1'b1, acc);
        drain();

        // Reset while waiting; the late memory pulse must not produce a response.
        mem_lat = 2;
        r1 = rcnt1;
        issue(1, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0, 1'b0, acc);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_wait_norsp", rcnt1, r1);
        check("rst_wait_rdata1", rsp1_rdata, 32'd0);
        @(posedge clk); #1;
        mem_lat = 1;
        issue(1, 1'b0, 32'h8, 32'h0, 32'h2, 1'b0, 1'b1, acc);
        drain();
        gport.delete(); gcyc.delete();
        fork
            begin int a0; issue(0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, a0); end
            begin int a1; issue(1, 1'b0, 32'h4, 32'h0, 32'h1, 1'b0, 1'b1, a1); end
        join
        drain();
        check("tie_after_rst", (gport.size() > 0) ? gport[0] : -1, 32'd0);

        // Both ports requesting continuously from reset: grants alternate every 4 cycles.
        do_reset();
        gport.delete(); gcyc.delete();
        fork
            begin int a0;
                issue(0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, a0);
                issue(0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, a0);
            end
            begin int a1;
                issue(1, 1'b0, 32'h4, 32'h0, 32'h1, 1'b0, 1'b1, a1);
                issue(1, 1'b0, 32'h4, 32'h0, 32'h1, 1'b0, 1'b1, a1);
            end
        join
        drain();
        check("rr_grants", gport.size(), 32'd4);
        for (int i = 0; i < 4 && i < gport.size(); i++) begin
            check("rr_port", gport[i], i % 2);
            if (i > 0) check("rr_spacing", gcyc[i] - gcyc[i-1], 32'd4);
        end

`ifdef MEM_ARB_TIMEOUT_EN
        mem_silent = 1'b1;
        issue(0, 1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b1, acc);
        drain();
        check("timeout_latency", rsp_cyc0 - acc, 32'd17);
        mem_silent = 1'b0;
        issue(0, 1'b0, 32'h24, 32'h0, 32'h9, 1'b0, 1'b1, acc);
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

endmodule
